// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register_file write port, with a clear pass of R0..R30 after every reset.
// Define REGFILE_ARB_STATS_EN to add saturating per-port grant and zero-register drop counters.
//   state | meaning
//   CLEAR | zeroing R0..ZERO_REG-1, requesters held off
//   RUN   | round-robin arbitration between port 0 and port 1
module regfile_write_arbiter #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wa,
    output logic [DATA_W-1:0] rf_wd,
    output logic              init_busy
`ifdef REGFILE_ARB_STATS_EN
    ,
    output logic [15:0]       grant0_cnt,
    output logic [15:0]       grant1_cnt,
    output logic [7:0]        zero_drop_cnt
`endif
);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
    localparam logic [ADDR_W-1:0] LAST_CLR  = ADDR_W'(ZERO_REG - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clear_ptr_q, clear_ptr_d;
    logic              last_grant_q, last_grant_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_wa_q, rf_wa_d;
    logic [DATA_W-1:0] rf_wd_q, rf_wd_d;
    logic              xfer;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    always_comb begin
        state_d      = state_q;
        clear_ptr_d  = clear_ptr_q;
        last_grant_d = last_grant_q;
        rf_we_d      = 1'b0;
        rf_wa_d      = rf_wa_q;
        rf_wd_d      = rf_wd_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        xfer         = 1'b0;
        sel_addr     = req0_addr;
        sel_data     = req0_data;
        case (state_q)
            S_CLEAR: begin
                rf_we_d = 1'b1;
                rf_wa_d = clear_ptr_q;
                rf_wd_d = '0;
                // Pointer stops at the last cleared address instead of wrapping.
                if (clear_ptr_q == LAST_CLR) begin
                    state_d = S_RUN;
                end else begin
                    clear_ptr_d = clear_ptr_q + 1'b1;
                end
            end
            S_RUN: begin
                if (req0_valid && (!req1_valid || last_grant_q)) begin
                    req0_ready   = 1'b1;
                    last_grant_d = 1'b0;
                end else if (req1_valid) begin
                    req1_ready   = 1'b1;
                    last_grant_d = 1'b1;
                    sel_addr     = req1_addr;
                    sel_data     = req1_data;
                end
                xfer = req0_ready | req1_ready;
                if (xfer && sel_addr != ZERO_ADDR) begin
                    rf_we_d = 1'b1;
                    rf_wa_d = sel_addr;
                    rf_wd_d = sel_data;
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_CLEAR;
            clear_ptr_q  <= '0;
            last_grant_q <= 1'b1;
            rf_we_q      <= 1'b0;
            rf_wa_q      <= '0;
            rf_wd_q      <= '0;
        end else begin
            state_q      <= state_d;
            clear_ptr_q  <= clear_ptr_d;
            last_grant_q <= last_grant_d;
            rf_we_q      <= rf_we_d;
            rf_wa_q      <= rf_wa_d;
            rf_wd_q      <= rf_wd_d;
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_wa     = rf_wa_q;
    assign rf_wd     = rf_wd_q;
    assign init_busy = (state_q == S_CLEAR);

`ifdef REGFILE_ARB_STATS_EN
    logic [15:0] grant0_cnt_q, grant1_cnt_q;
    logic [7:0]  zero_drop_cnt_q;
    logic        zero_drop;

    assign zero_drop = xfer && (sel_addr == ZERO_ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            grant0_cnt_q    <= '0;
            grant1_cnt_q    <= '0;
            zero_drop_cnt_q <= '0;
        end else begin
            if (req0_valid && req0_ready && grant0_cnt_q != '1)
                grant0_cnt_q <= grant0_cnt_q + 1'b1;
            if (req1_valid && req1_ready && grant1_cnt_q != '1)
                grant1_cnt_q <= grant1_cnt_q + 1'b1;
            if (zero_drop && zero_drop_cnt_q != '1)
                zero_drop_cnt_q <= zero_drop_cnt_q + 1'b1;
        end
    end

    assign grant0_cnt    = grant0_cnt_q;
    assign grant1_cnt    = grant1_cnt_q;
    assign zero_drop_cnt = zero_drop_cnt_q;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: clear pass, handshake latency, round-robin, ZERO_REG drop, resets.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_addr, req1_addr;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        init_busy;
`ifdef REGFILE_ARB_STATS_EN
    logic [15:0] grant0_cnt, grant1_cnt;
    logic [7:0]  zero_drop_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .rf_we      (rf_we),
        .rf_wa      (rf_wa),
        .rf_wd      (rf_wd),
        .init_busy  (init_busy)
`ifdef REGFILE_ARB_STATS_EN
        ,
        .grant0_cnt    (grant0_cnt),
        .grant1_cnt    (grant1_cnt),
        .zero_drop_cnt (zero_drop_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 ns after the rising edge; inputs are driven at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state();
        chk("rst_we", 32'(rf_we), 32'd0);
        chk("rst_wa", 32'(rf_wa), 32'd0);
        chk("rst_wd", rf_wd, 32'd0);
        chk("rst_busy", 32'(init_busy), 32'd1);
    endtask

    task automatic check_clear_step(input int i);
        chk($sformatf("clr_we[%0d]", i), 32'(rf_we), 32'd1);
        chk($sformatf("clr_wa[%0d]", i), 32'(rf_wa), 32'(i));
        chk($sformatf("clr_wd[%0d]", i), rf_wd, 32'd0);
        chk($sformatf("clr_busy[%0d]", i), 32'(init_busy), (i == 30) ? 32'd0 : 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        tick();
        rst = 1'b0;
        check_reset_state();
        #1;
        chk("clr_rdy0_idle", 32'(req0_ready), 32'd0);

        // Clear pass; port 0 raises a request two cycles in and must be held off.
        for (int i = 0; i < 31; i++) begin
            tick();
            check_clear_step(i);
            if (i == 1) begin
                req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
            end
            #1;
            if (i < 30) chk($sformatf("clr_rdy0[%0d]", i), 32'(req0_ready), 32'd0);
            else        chk("run_rdy0", 32'(req0_ready), 32'd1);
        end
        tick();
        req0_valid = 1'b0;
        chk("w5_we", 32'(rf_we), 32'd1);
        chk("w5_wa", 32'(rf_wa), 32'd5);
        chk("w5_wd", rf_wd, 32'hDEADBEEF);
        #1;
        chk("idle_rdy0", 32'(req0_ready), 32'd0);
        chk("idle_rdy1", 32'(req1_ready), 32'd0);
        tick();
        chk("w5_we_off", 32'(rf_we), 32'd0);
        chk("w5_wa_hold", 32'(rf_wa), 32'd5);
        chk("w5_wd_hold", rf_wd, 32'hDEADBEEF);

        // Write to the hardwired-zero register is consumed without a write.
        req1_valid = 1'b1; req1_addr = 5'd31; req1_data = 32'hFFFFFFFF;
        #1;
        chk("z_rdy1", 32'(req1_ready), 32'd1);
        chk("z_rdy0", 32'(req0_ready), 32'd0);
        tick();
        req1_valid = 1'b0;
        chk("z_we", 32'(rf_we), 32'd0);
        chk("z_wa_hold", 32'(rf_wa), 32'd5);
`ifdef REGFILE_ARB_STATS_EN
        chk("z_cnt", 32'(zero_drop_cnt), 32'd1);
`endif

        // Last grant was port 1, so both-valid alternation starts with port 0.
        req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h11;
        req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h22;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("rr_rdy0[%0d]", k), 32'(req0_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("rr_rdy1[%0d]", k), 32'(req1_ready), (k % 2 == 1) ? 32'd1 : 32'd0);
            tick();
            chk($sformatf("rr_we[%0d]", k), 32'(rf_we), 32'd1);
            chk($sformatf("rr_wa[%0d]", k), 32'(rf_wa), (k % 2 == 0) ? 32'd1 : 32'd2);
            chk($sformatf("rr_wd[%0d]", k), rf_wd, (k % 2 == 0) ? 32'h11 : 32'h22);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        chk("rr_we_off", 32'(rf_we), 32'd0);
`ifdef REGFILE_ARB_STATS_EN
        chk("cnt_g0", 32'(grant0_cnt), 32'd4);
        chk("cnt_g1", 32'(grant1_cnt), 32'd4);
`endif

        // Port 1 alone, then reset on the same edge as a transfer: the write is discarded.
        req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'h77;
        #1;
        chk("solo_rdy1", 32'(req1_ready), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req1_valid = 1'b0;
        check_reset_state();
`ifdef REGFILE_ARB_STATS_EN
        chk("rst_g0", 32'(grant0_cnt), 32'd0);
        chk("rst_g1", 32'(grant1_cnt), 32'd0);
        chk("rst_z", 32'(zero_drop_cnt), 32'd0);
`endif

        // Reset mid-clear with clear_ptr at 10 restarts from address 0.
        for (int i = 0; i < 10; i++) begin
            tick();
            check_clear_step(i);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state();
        for (int i = 0; i < 31; i++) begin
            tick();
            check_clear_step(i);
        end
        tick();
        chk("post_clr_we", 32'(rf_we), 32'd0);
        chk("post_clr_wa", 32'(rf_wa), 32'd30);
        chk("post_clr_busy", 32'(init_busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the Beta register_file between two requesters.
  - Port 0: execute/writeback stage.
  - Port 1: debug/loader unit.
- Uses round-robin arbitration with a valid/ready handshake.
- After every reset, sequences a clear pass that zeroes R0..R30 before any requester is granted.
- Sits between the writeback logic and the register_file WriteAddress/WritePort/WriteEnable inputs.

Parameters:
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- ZERO_REG, 31, hardwired-zero register index; never written.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  port 0 write request.
- req0_addr  input  ADDR_W  port 0 target register.
- req0_data  input  DATA_W  port 0 write data.
- req0_ready  output  1  port 0 granted this cycle.
- req1_valid  input  1  port 1 write request.
- req1_addr  input  ADDR_W  port 1 target register.
- req1_data  input  DATA_W  port 1 write data.
- req1_ready  output  1  port 1 granted this cycle.
- rf_we  output  1  to register_file WriteEnable.
- rf_wa  output  ADDR_W  to register_file WriteAddress.
- rf_wd  output  DATA_W  to register_file WritePort.
- init_busy  output  1  clear pass in progress.

Behaviour:
- Reset (synchronous, any state):
  - state=CLEAR, clear_ptr=0, rf_we=0, rf_wa=0, rf_wd=0, init_busy=1.
  - last_grant=1, so port 0 wins the first tie.
  - A reset mid-clear or mid-run restarts the clear from address 0.
  - An in-flight registered write is discarded.
- FSM states: CLEAR, RUN.
- CLEAR:
  - Each cycle registers rf_we=1, rf_wa=clear_ptr, rf_wd=0, then clear_ptr++.
  - Covers addresses 0..ZERO_REG-1 (31 writes); ZERO_REG itself is never written.
  - After issuing address ZERO_REG-1, transition to RUN; init_busy deasserts in the same registered update.
  - req0_ready=req1_ready=0 throughout; requests are ignored, not lost, and requesters keep valid high.
- RUN, readies (combinational from valid and last_grant):
  - Only one valid: that port's ready=1.
  - Both valid: the port != last_grant gets ready=1, the other 0.
  - Neither valid: both readies 0.
- Transfer: valid && ready on a rising edge.
  - last_grant updates to the transferring port on every transfer.
  - Idle cycles leave last_grant unchanged.
- Requester rules:
  - Once asserted, valid holds with addr and data stable until ready.
  - The arbiter does not require valid to depend on ready.
- Write output, latency 1 cycle: on a transfer, the next cycle shows rf_we=1, rf_wa=addr, rf_wd=data.
  - No transfer: rf_we=0; rf_wa and rf_wd hold their last values.
- ZERO_REG requests: accepted (ready=1 as normal) but rf_we stays 0; the request is consumed silently.
- Throughput: one write per cycle sustained. Two continuously valid ports alternate 0,1,0,1…
- Same-address writes from both ports: serialized in grant order; the later grant wins.
- Widths: all address/data paths are exactly ADDR_W/DATA_W; clear_ptr is ADDR_W wide with no wrap (terminates at ZERO_REG-1).

Optional Feature:
- Macro: REGFILE_ARB_STATS_EN.
- Defined:
  - Adds outputs grant0_cnt, grant1_cnt (16 bits each) counting transfers per port.
  - Adds output zero_drop_cnt (8 bits) counting ZERO_REG requests consumed.
  - All counters reset to 0 on rst and saturate at all-ones.
  - Transfers during CLEAR are impossible, so nothing is counted there.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- rst high 1 cycle then low, no requests -> 31 consecutive cycles of rf_we=1, rf_wd=0, rf_wa=0..30; init_busy falls on the cycle after rf_wa=30 is issued; no write to 31.
- req0_valid=1 addr=5 data=0xDEADBEEF held from cycle 2 after reset -> req0_ready stays 0 until RUN; then ready=1 for one cycle; next cycle rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF; rf_we=0 after.
- In RUN, both ports continuously valid (port0 addr=1 data=0x11, port1 addr=2 data=0x22) for 6 cycles -> grants 0,1,0,1,0,1; rf_wa sequence 1,2,1,2,1,2 one cycle later.
- req1 addr=31 data=0xFFFFFFFF -> req1_ready=1; following cycle rf_we=0; zero_drop_cnt=1 if REGFILE_ARB_STATS_EN.
- rst asserted when clear_ptr=10 -> next clear writes restart at rf_wa=0; full 31-write sequence repeats; init_busy stays 1 throughout.
- With REGFILE_ARB_STATS_EN: 3 port0 and 2 port1 transfers -> grant0_cnt=3, grant1_cnt=2; rst -> both 0.
